// File: rtl/stream_demux_nch.sv
// stream_demux_nch: registered 1-to-N valid/ready demux with broadcast and out-of-range drop counting
module stream_demux_nch #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 2,
    parameter int SEL_W  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [7:0]               drop_cnt
);
    logic [N_CH-1:0]        r_valid;
    logic [N_CH*DATA_W-1:0] r_data;
    logic [7:0]             r_drop;
    logic [N_CH-1:0]        w_free;
    logic [N_CH-1:0]        w_hit;
    logic [N_CH-1:0]        w_load;
    logic                   w_in_range;
    logic                   w_accept;

    // one-hot decode of in_sel avoids indexing with an out-of-range select
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < N_CH; k++) w_hit[k] = (32'(in_sel) == k);
    end

    assign w_free     = ~r_valid | out_ready;
    assign w_in_range = |w_hit;
    assign in_ready   = in_bcast ? &w_free : (w_in_range ? |(w_free & w_hit) : 1'b1);
    assign w_accept   = in_valid & in_ready;
    assign w_load     = {N_CH{w_accept}} & (in_bcast ? {N_CH{1'b1}} : w_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (w_load[k]) begin
                    r_valid[k]                  <= 1'b1;
                    r_data[k*DATA_W +: DATA_W]  <= in_data;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_drop <= '0;
        else if (w_accept && !in_bcast && !w_in_range && r_drop != 8'hFF)
            r_drop <= r_drop + 8'd1;
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign drop_cnt  = r_drop;
endmodule

// File: tb/tb_stream_demux_nch.sv
// tb_stream_demux_nch: directed vector table on a 3-channel instance plus a scoreboarded random run on a 2-channel instance
module tb_stream_demux_nch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid, a_ready, a_bcast;
    logic [7:0]  a_data;
    logic [1:0]  a_sel;
    logic [2:0]  a_ovalid, a_ordy;
    logic [23:0] a_odata;
    logic [7:0]  a_drop;
    logic        b_valid, b_ready, b_bcast;
    logic [7:0]  b_data;
    logic [0:0]  b_sel;
    logic [1:0]  b_ovalid, b_ordy;
    logic [15:0] b_odata;
    logic [7:0]  b_drop;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    stream_demux_nch #(.DATA_W(8), .N_CH(3), .SEL_W(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_sel(a_sel), .in_bcast(a_bcast), .out_valid(a_ovalid), .out_ready(a_ordy),
        .out_data(a_odata), .drop_cnt(a_drop));

    stream_demux_nch u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_sel(b_sel), .in_bcast(b_bcast), .out_valid(b_ovalid), .out_ready(b_ordy),
        .out_data(b_odata), .drop_cnt(b_drop));

    typedef struct {
        logic        v;
        logic        b;
        logic [1:0]  s;
        logic [7:0]  d;
        logic [2:0]  r;
        logic        er;
        logic [2:0]  ev;
        logic [23:0] ed;
        logic [7:0]  edr;
    } vec_t;

    vec_t tbl [16];
    logic [7:0] q [2][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_a(input logic v, input logic b, input logic [1:0] s, input logic [7:0] d, input logic [2:0] r);
        a_valid = v; a_bcast = b; a_sel = s; a_data = d; a_ordy = r;
    endtask

    task automatic step_a(input int i);
        drive_a(tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].d, tbl[i].r);
        #1 chk($sformatf("v%0d in_ready", i), 32'(a_ready), 32'(tbl[i].er));
        @(posedge clk); #1;
        chk($sformatf("v%0d out_valid", i), 32'(a_ovalid), 32'(tbl[i].ev));
        chk($sformatf("v%0d out_data", i), 32'(a_odata), 32'(tbl[i].ed));
        chk($sformatf("v%0d drop_cnt", i), 32'(a_drop), 32'(tbl[i].edr));
    endtask

    initial begin
        logic [1:0] free;
        logic [7:0] seq;
        drive_a(0, 0, 0, 0, 3'b000);
        b_valid = 0; b_bcast = 0; b_sel = 0; b_data = 0; b_ordy = 0;
        //        v  b  sel    data    ordy     rdy  ovalid   odata        drop
        tbl[0]  = '{1, 0, 2'd0, 8'h11, 3'b111, 1, 3'b001, 24'h000011, 8'd0};
        tbl[1]  = '{1, 0, 2'd1, 8'h22, 3'b111, 1, 3'b010, 24'h002211, 8'd0};
        tbl[2]  = '{1, 0, 2'd2, 8'h33, 3'b111, 1, 3'b100, 24'h332211, 8'd0};
        tbl[3]  = '{0, 0, 2'd0, 8'h00, 3'b111, 1, 3'b000, 24'h332211, 8'd0};
        tbl[4]  = '{1, 0, 2'd1, 8'hA5, 3'b101, 1, 3'b010, 24'h33A511, 8'd0};
        tbl[5]  = '{1, 0, 2'd1, 8'h77, 3'b101, 0, 3'b010, 24'h33A511, 8'd0};
        tbl[6]  = '{1, 0, 2'd0, 8'h44, 3'b101, 1, 3'b011, 24'h33A544, 8'd0};
        tbl[7]  = '{1, 0, 2'd1, 8'h66, 3'b111, 1, 3'b010, 24'h336644, 8'd0};
        tbl[8]  = '{0, 0, 2'd0, 8'h00, 3'b111, 1, 3'b000, 24'h336644, 8'd0};
        tbl[9]  = '{1, 0, 2'd2, 8'h99, 3'b011, 1, 3'b100, 24'h996644, 8'd0};
        tbl[10] = '{1, 1, 2'd0, 8'h5A, 3'b011, 0, 3'b100, 24'h996644, 8'd0};
        tbl[11] = '{1, 1, 2'd0, 8'h5A, 3'b111, 1, 3'b111, 24'h5A5A5A, 8'd0};
        tbl[12] = '{1, 1, 2'd3, 8'hC3, 3'b111, 1, 3'b111, 24'hC3C3C3, 8'd0};
        tbl[13] = '{0, 0, 2'd0, 8'h00, 3'b000, 0, 3'b111, 24'hC3C3C3, 8'd0};
        tbl[14] = '{1, 0, 2'd3, 8'hEE, 3'b000, 1, 3'b111, 24'hC3C3C3, 8'd1};
        tbl[15] = '{0, 0, 2'd3, 8'h00, 3'b111, 1, 3'b000, 24'hC3C3C3, 8'd1};
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset out_valid", 32'(a_ovalid), 0);
        chk("reset out_data", 32'(a_odata), 0);
        chk("reset drop_cnt", 32'(a_drop), 0);
        for (int i = 0; i < 16; i++) step_a(i);

        // 254 more dropped beats reach exactly 255, then the counter must hold
        for (int i = 0; i < 254; i++) begin
            drive_a(1, 0, 2'd3, 8'(i), 3'b111);
            @(posedge clk); #1;
        end
        chk("drop at 255", 32'(a_drop), 255);
        for (int i = 0; i < 5; i++) begin
            drive_a(1, 0, 2'd3, 8'hF0, 3'b111);
            #1 chk("drop in_ready", 32'(a_ready), 1);
            @(posedge clk); #1;
        end
        chk("drop saturated", 32'(a_drop), 255);
        chk("drop no out_valid", 32'(a_ovalid), 0);

        drive_a(1, 1, 2'd0, 8'h3C, 3'b000);
        @(posedge clk); #1;
        drive_a(0, 0, 2'd0, 8'h00, 3'b010);
        @(posedge clk); #1;
        chk("pre-reset out_valid", 32'(a_ovalid), 32'b101);
        drive_a(0, 0, 2'd0, 8'h00, 3'b000);
        #2 rst = 1;
        #1;
        chk("async reset out_valid", 32'(a_ovalid), 0);
        chk("async reset out_data", 32'(a_odata), 0);
        chk("async reset drop_cnt", 32'(a_drop), 0);
        chk("reset in_ready", 32'(a_ready), 1);
        @(posedge clk); #1 rst = 0;

        seq = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            b_valid = 1'($urandom_range(0, 1));
            b_bcast = ($urandom_range(0, 7) == 0);
            b_sel   = 1'($urandom_range(0, 1));
            b_data  = seq;
            b_ordy  = 2'($urandom_range(0, 3));
            @(negedge clk);
            free = ~b_ovalid | b_ordy;
            chk("rand in_ready", 32'(b_ready), 32'(b_bcast ? &free : free[b_sel]));
            for (int k = 0; k < 2; k++) begin
                if (b_ovalid[k] && b_ordy[k]) begin
                    if (q[k].size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL rand ch%0d: got beat %h, expected no pending beat", k, b_odata[k*8 +: 8]);
                    end else
                        chk($sformatf("rand ch%0d data", k), 32'(b_odata[k*8 +: 8]), 32'(q[k].pop_front()));
                end
            end
            if (b_valid && b_ready) begin
                if (b_bcast) begin q[0].push_back(seq); q[1].push_back(seq); end
                else q[b_sel].push_back(seq);
                seq = seq + 8'd1;
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 2; k++)
            chk($sformatf("rand ch%0d pending", k), 32'(q[k].size()), 32'(b_ovalid[k]));
        chk("rand drop_cnt", 32'(b_drop), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
